// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - handshake bundle for the arbitrated N:1 register mux
//
// Purpose: groups the N request channels and the single downstream port of
// rr_arb_mux so that one interface instance connects upstream, mux and
// downstream.
// Signals:
//   in_valid  [NUM_IN]        per-channel request valid
//   in_data   [NUM_IN*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_ready  [NUM_IN]        per-channel accept, one-hot or zero
//   out_valid                 output register holds a word
//   out_data  [WIDTH]         registered word of the granted channel
//   out_sel   [SEL_W]         index of the channel that produced out_data
//   out_ready                 downstream accept
// Modports: master = requesters/downstream side, slave = the mux.
interface rr_arb_mux_if #(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 64
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-input arbitrated mux with one output register stage
//
// Purpose: shares one downstream port between NUM_IN requesters. An internal
// arbiter (round-robin or fixed lowest-index priority) picks the channel; the
// chosen word is captured in an output register (1-cycle latency, full
// throughput, back-to-back pop/push without a bubble).
// Ports:
//   clk_i    clock, rising edge
//   reset_i  synchronous, active-high; clears the output register and pointer
//   bus_io   rr_arb_mux_if.slave: in_valid/in_data/in_ready requester side,
//            out_valid/out_data/out_sel/out_ready downstream side
module rr_arb_mux #(
  parameter int NUM_IN  = 2,
  parameter int WIDTH   = 64,
  parameter int RR_MODE = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  rr_arb_mux_if.slave  bus_io
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic              load_en;
  logic              xfer;
  logic              gnt_found;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  scan_base;
  logic [SEL_W-1:0]  cand;
  int                scan_idx;
  logic [NUM_IN-1:0] in_ready_c;

  always_comb begin
    load_en   = !out_valid_q || bus_io.out_ready;
    // Fixed-priority mode ignores the pointer and always scans from channel 0.
    scan_base = (RR_MODE != 0) ? ptr_q : '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    cand      = '0;
    // Scan upward from scan_base, wrapping past NUM_IN-1 back to 0.
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = int'(scan_base) + k;
      if (scan_idx >= NUM_IN) scan_idx = scan_idx - NUM_IN;
      cand = SEL_W'(scan_idx);
      if (!gnt_found && bus_io.in_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end

    // No channel is accepted while reset is asserted.
    xfer = !reset_i && load_en && gnt_found;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready_c[i] = xfer && (gnt_idx == SEL_W'(i));
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      // With nothing to load the word is popped; data/sel keep their values.
      out_valid_d = gnt_found;
      if (gnt_found) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (gnt_idx == SEL_W'(i)) out_data_d = bus_io.in_data[i*WIDTH +: WIDTH];
        end
        out_sel_d = gnt_idx;
        if (RR_MODE != 0) begin
          ptr_d = (gnt_idx == SEL_W'(NUM_IN-1)) ? '0 : gnt_idx + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus_io.in_ready  = in_ready_c;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed self-checking bench for rr_arb_mux
module tb_rr_arb_mux;
  localparam int N = 3;
  localparam int W = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rr_arb_mux_if #(.NUM_IN(N), .WIDTH(W)) a_if ();
  rr_arb_mux_if #(.NUM_IN(N), .WIDTH(W)) b_if ();

  rr_arb_mux #(.NUM_IN(N), .WIDTH(W), .RR_MODE(1)) u_rr (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (a_if.slave)
  );

  rr_arb_mux #(.NUM_IN(N), .WIDTH(W), .RR_MODE(0)) u_fp (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive channel data with a recognisable per-channel pattern.
  task automatic set_data_a(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
    a_if.in_data = {d2, d1, d0};
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel;
    n_checks = 0;
    n_fail   = 0;

    a_if.in_valid  = '0;
    a_if.in_data   = '0;
    a_if.out_ready = 1'b1;
    b_if.in_valid  = '0;
    b_if.in_data   = '0;
    b_if.out_ready = 1'b1;
    reset          = 1'b1;

    // 1: reset held 2 cycles with every channel valid
    @(negedge clk);
    a_if.in_valid = 3'b111;
    b_if.in_valid = 3'b111;
    set_data_a(64'h11, 64'h22, 64'h33);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst_in_ready_rr", 64'(a_if.in_ready), 64'h0);
      check("rst_in_ready_fp", 64'(b_if.in_ready), 64'h0);
      tick();
      check("rst_out_valid", 64'(a_if.out_valid), 64'h0);
      check("rst_out_data", a_if.out_data, 64'h0);
      check("rst_out_sel", 64'(a_if.out_sel), 64'h0);
      @(negedge clk);
    end
    reset = 1'b0;
    a_if.in_valid = '0;
    b_if.in_valid = '0;

    // 2: only channel 1 valid
    set_data_a(64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0);
    a_if.in_valid = 3'b010;
    #1;
    check("single_in_ready", 64'(a_if.in_ready), 64'h2);
    tick();
    check("single_out_valid", 64'(a_if.out_valid), 64'h1);
    check("single_out_data", a_if.out_data, 64'hDEAD_BEEF_0000_0001);
    check("single_out_sel", 64'(a_if.out_sel), 64'h1);
    // Idle with load_en high: word popped, data and sel hold.
    @(negedge clk);
    a_if.in_valid = '0;
    tick();
    check("idle_out_valid", 64'(a_if.out_valid), 64'h0);
    check("idle_out_data_hold", a_if.out_data, 64'hDEAD_BEEF_0000_0001);
    check("idle_out_sel_hold", 64'(a_if.out_sel), 64'h1);

    // 3: round-robin after a fresh reset, all channels valid
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
    set_data_a(64'h1000, 64'h1001, 64'h1002);
    a_if.in_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_sel = c % 3;
      #1;
      check("rr_in_ready", 64'(a_if.in_ready), 64'(1) << exp_sel);
      tick();
      check("rr_out_sel", 64'(a_if.out_sel), 64'(exp_sel));
      check("rr_out_data", a_if.out_data, 64'h1000 + 64'(exp_sel));
      check("rr_out_valid", 64'(a_if.out_valid), 64'h1);
      @(negedge clk);
    end

    // 4: backpressure with out_sel=2 held, channel 0 waiting
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 3'b001;
    set_data_a(64'hA0, 64'hA1, 64'hA2);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", 64'(a_if.in_ready), 64'h0);
      tick();
      check("stall_out_valid", 64'(a_if.out_valid), 64'h1);
      check("stall_out_sel", 64'(a_if.out_sel), 64'h2);
      check("stall_out_data", a_if.out_data, 64'h1002);
      @(negedge clk);
    end
    a_if.out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 64'(a_if.in_ready), 64'h1);
    tick();
    check("unstall_out_sel", 64'(a_if.out_sel), 64'h0);
    check("unstall_out_data", a_if.out_data, 64'hA0);
    @(negedge clk);
    a_if.in_valid = '0;

    // 5: fixed priority, channels 0 and 2 valid
    b_if.in_data  = {64'hB2, 64'hB1, 64'hB0};
    b_if.in_valid = 3'b101;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("fp_in_ready", 64'(b_if.in_ready), 64'h1);
      check("fp_ch2_ready", 64'(b_if.in_ready[2]), 64'h0);
      tick();
      check("fp_out_sel", 64'(b_if.out_sel), 64'h0);
      check("fp_out_data", b_if.out_data, 64'hB0);
      @(negedge clk);
    end
    b_if.in_valid = '0;

    // 6: reset during a stall; pointer left at 2 beforehand
    set_data_a(64'hC0, 64'hC1, 64'hC2);
    a_if.in_valid = 3'b010;
    tick();
    check("pre6_out_sel", 64'(a_if.out_sel), 64'h1);
    @(negedge clk);
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 3'b111;
    tick();
    check("pre6_stall_valid", 64'(a_if.out_valid), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst6_in_ready", 64'(a_if.in_ready), 64'h0);
    tick();
    check("rst6_out_valid", 64'(a_if.out_valid), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    a_if.out_ready = 1'b1;
    #1;
    check("post6_in_ready", 64'(a_if.in_ready), 64'h1);
    tick();
    check("post6_out_sel", 64'(a_if.out_sel), 64'h0);
    check("post6_out_data", a_if.out_data, 64'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
